// File: rtl/pll_reset_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, filters lock, then releases
// the domain resets in staggered order; restarts on timeout, lock loss or request.
module pll_reset_seq #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_FILTER  = 1024,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int STAGGER      = 64,
    parameter int NUM_DOM      = 3
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               req_reset,
    output logic               pll_rst,
    output logic [NUM_DOM-1:0] dom_rst,
    output logic               ready,
    output logic [7:0]         retries,
    output logic               lock_lost
);

    localparam int REL_DONE = STAGGER * (NUM_DOM - 1) + 1;
    localparam int CNT_MAX  = (RST_CYCLES > LOCK_FILTER)
                            ? ((RST_CYCLES > REL_DONE) ? RST_CYCLES : REL_DONE)
                            : ((LOCK_FILTER > REL_DONE) ? LOCK_FILTER : REL_DONE);
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int TMO_W    = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLT_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_DONE);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        FILTER,
        RELEASE,
        RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TMO_W-1:0] tmo;
    logic             sync1;
    logic             locked_s;

    // pll_locked comes from the PLL's own clocking, so resynchronize it
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= pll_locked;
            locked_s <= sync1;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= PLL_RST;
            cnt       <= '0;
            tmo       <= '0;
            pll_rst   <= 1'b1;
            dom_rst   <= '1;
            ready     <= 1'b0;
            retries   <= '0;
            lock_lost <= 1'b0;
        end else begin
            lock_lost <= 1'b0;
            if (req_reset && state != PLL_RST) begin
                state   <= PLL_RST;
                cnt     <= '0;
                pll_rst <= 1'b1;
                dom_rst <= '1;
                ready   <= 1'b0;
            end else begin
                case (state)
                    PLL_RST: begin
                        if (req_reset) begin
                            cnt <= '0;
                        end else if (cnt == RST_LAST) begin
                            state   <= WAIT_LOCK;
                            cnt     <= '0;
                            tmo     <= '0;
                            pll_rst <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT_LOCK, FILTER: begin
                        // tmo spans both states so a flapping lock still times out
                        if (tmo == TMO_LAST) begin
                            state   <= PLL_RST;
                            cnt     <= '0;
                            pll_rst <= 1'b1;
                            if (retries != 8'hFF) retries <= retries + 8'd1;
                        end else begin
                            tmo <= tmo + 1'b1;
                            if (state == WAIT_LOCK) begin
                                if (locked_s) begin
                                    state <= FILTER;
                                    cnt   <= '0;
                                end
                            end else if (!locked_s) begin
                                state <= WAIT_LOCK;
                                cnt   <= '0;
                            end else if (cnt == FLT_LAST) begin
                                state <= RELEASE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    RELEASE, RUN: begin
                        if (!locked_s) begin
                            state     <= PLL_RST;
                            cnt       <= '0;
                            pll_rst   <= 1'b1;
                            dom_rst   <= '1;
                            ready     <= 1'b0;
                            lock_lost <= 1'b1;
                        end else if (state == RELEASE) begin
                            cnt <= cnt + 1'b1;
                            for (int i = 0; i < NUM_DOM; i++) begin
                                if (cnt == CNT_W'(STAGGER * i)) dom_rst[i] <= 1'b0;
                            end
                            if (cnt == REL_LAST) begin
                                state <= RUN;
                                cnt   <= '0;
                                ready <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state   <= PLL_RST;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        dom_rst <= '1;
                        ready   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: directed scenarios plus random lock/request traffic,
// every cycle compared against a phase/age reference model.
module tb_pll_reset_seq;

    localparam int RC  = 4;
    localparam int LF  = 8;
    localparam int LT  = 100;
    localparam int STG = 2;
    localparam int ND  = 3;

    localparam int PH_RST  = 0;
    localparam int PH_LOCK = 1;
    localparam int PH_REL  = 2;
    localparam int PH_RUN  = 3;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          req_reset = 1'b0;
    logic          pll_rst;
    logic [ND-1:0] dom_rst;
    logic          ready;
    logic [7:0]    retries;
    logic          lock_lost;

    int vec  = 0;
    int errs = 0;

    pll_reset_seq #(
        .RST_CYCLES  (RC),
        .LOCK_FILTER (LF),
        .LOCK_TIMEOUT(LT),
        .STAGGER     (STG),
        .NUM_DOM     (ND)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .req_reset (req_reset),
        .pll_rst   (pll_rst),
        .dom_rst   (dom_rst),
        .ready     (ready),
        .retries   (retries),
        .lock_lost (lock_lost)
    );

    always #5 refclk = ~refclk;

    // Reference model: a phase plus "age" counters (edges spent in the phase);
    // WAIT_LOCK and FILTER collapse into one lock phase with a run length.
    int m_ph, m_age, m_tmo, m_run, m_retries;
    bit m_s1, m_ls, m_lost;

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            m_ph <= PH_RST; m_age <= 0; m_tmo <= 0; m_run <= 0;
            m_retries <= 0; m_s1 <= 0; m_ls <= 0; m_lost <= 0;
        end else begin
            m_s1   <= pll_locked;
            m_ls   <= m_s1;
            m_lost <= 0;
            case (m_ph)
                PH_RST: begin
                    if (req_reset) m_age <= 0;
                    else if (m_age + 1 == RC) begin
                        m_ph <= PH_LOCK; m_tmo <= 0; m_run <= 0;
                    end else m_age <= m_age + 1;
                end
                PH_LOCK: begin
                    if (req_reset) begin
                        m_ph <= PH_RST; m_age <= 0;
                    end else if (m_tmo + 1 == LT) begin
                        m_ph <= PH_RST; m_age <= 0;
                        if (m_retries < 255) m_retries <= m_retries + 1;
                    end else begin
                        m_tmo <= m_tmo + 1;
                        if (!m_ls) m_run <= 0;
                        else if (m_run + 1 == LF + 1) begin
                            m_ph <= PH_REL; m_age <= 0;
                        end else m_run <= m_run + 1;
                    end
                end
                default: begin
                    if (req_reset) begin
                        m_ph <= PH_RST; m_age <= 0;
                    end else if (!m_ls) begin
                        m_ph <= PH_RST; m_age <= 0; m_lost <= 1;
                    end else if (m_ph == PH_REL) begin
                        if (m_age + 1 == STG * (ND - 1) + 2) m_ph <= PH_RUN;
                        m_age <= m_age + 1;
                    end
                end
            endcase
        end
    end

    logic [ND-1:0] e_dom;
    always_comb begin
        e_dom = '1;
        for (int i = 0; i < ND; i++)
            if (m_ph == PH_RUN || (m_ph == PH_REL && m_age >= STG * i + 1)) e_dom[i] = 1'b0;
    end

    logic [ND+10:0] obs, expv;
    assign obs  = {pll_rst, dom_rst, ready, retries, lock_lost};
    assign expv = {m_ph == PH_RST, e_dom, m_ph == PH_RUN, 8'(m_retries), m_lost};

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge refclk);
        vec++;
        if (obs !== {1'b1, 3'b111, 1'b0, 8'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset_values: {pll_rst,dom_rst,ready,retries,lock_lost} got %b expected %b",
                     obs, {1'b1, 3'b111, 1'b0, 8'd0, 1'b0});
        end
        rst = 1'b0;
    endtask

    task automatic test_bringup;
        int first_low = -1, rdy_at = -1;
        int clr [ND];
        for (int k = 0; k < ND; k++) clr[k] = -1;
        pll_locked = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge refclk); vec++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL bringup cycle %0d: got %b expected %b", i, obs, expv);
            end
            if (first_low < 0 && !pll_rst) first_low = i;
            for (int k = 0; k < ND; k++) if (clr[k] < 0 && !dom_rst[k]) clr[k] = i;
            if (rdy_at < 0 && ready) rdy_at = i;
            if (i == 9) pll_locked = 1'b1;
        end
        vec++;
        if (first_low !== RC) begin
            errs++; $display("FAIL bringup_pll_rst_width: got %0d expected %0d", first_low, RC);
        end
        // lock set after cycle 9: 2 sync edges, LF+1 filter edges, then first release edge
        vec++;
        if (clr[0] !== 9 + 2 + (LF + 1) + 1) begin
            errs++; $display("FAIL bringup_dom0_release: got %0d expected %0d", clr[0], 9 + 2 + (LF + 1) + 1);
        end
        for (int k = 1; k < ND; k++) begin
            vec++;
            if (clr[k] - clr[0] !== STG * k) begin
                errs++; $display("FAIL bringup_stagger dom %0d: got %0d expected %0d", k, clr[k] - clr[0], STG * k);
            end
        end
        vec++;
        if (rdy_at !== clr[ND-1] + 1) begin
            errs++; $display("FAIL bringup_ready: got %0d expected %0d", rdy_at, clr[ND-1] + 1);
        end
        vec++;
        if (retries !== 8'd0 || ready !== 1'b1) begin
            errs++; $display("FAIL bringup_final: retries %0d ready %b expected 0 1", retries, ready);
        end
    endtask

    task automatic test_glitch;
        int first_clr = -1, lost_cnt = 0;
        req_reset  = 1'b1;
        pll_locked = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            @(negedge refclk); vec++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL glitch cycle %0d: got %b expected %b", j, obs, expv);
            end
            if (first_clr < 0 && dom_rst !== 3'b111) first_clr = j;
            if (lock_lost) lost_cnt++;
            req_reset  = 1'b0;
            pll_locked = (j >= 5 && j != 10);
        end
        // steady lock from cycle 11: filter restarts, release seen at cycle 23
        vec++;
        if (first_clr !== 23) begin
            errs++; $display("FAIL glitch_release_time: got %0d expected 23", first_clr);
        end
        vec++;
        if (lost_cnt !== 0) begin
            errs++; $display("FAIL glitch_lock_lost: got %0d pulses expected 0", lost_cnt);
        end
    endtask

    task automatic test_lock_loss;
        pll_locked = 1'b0;
        for (int j = 1; j <= 50; j++) begin
            @(negedge refclk); vec++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL lock_loss cycle %0d: got %b expected %b", j, obs, expv);
            end
            if (j == 2) begin
                vec++;
                if ({lock_lost, ready} !== 2'b01) begin
                    errs++; $display("FAIL lock_loss_early: lock_lost,ready got %b expected 01", {lock_lost, ready});
                end
            end
            if (j == 3) begin
                vec++;
                if ({lock_lost, dom_rst, ready, pll_rst} !== 6'b1_111_0_1) begin
                    errs++;
                    $display("FAIL lock_loss_pulse: {lost,dom,ready,pll_rst} got %b expected 111101",
                             {lock_lost, dom_rst, ready, pll_rst});
                end
            end
            if (j == 4) begin
                vec++;
                if (lock_lost !== 1'b0) begin
                    errs++; $display("FAIL lock_loss_width: got %b expected 0", lock_lost);
                end
            end
            if (j == 5) pll_locked = 1'b1;
        end
        vec++;
        if (ready !== 1'b1) begin
            errs++; $display("FAIL lock_loss_recover: ready got %b expected 1", ready);
        end
    endtask

    task automatic test_req_hold;
        int pr_cnt = 0, lost_cnt = 0;
        int r0 = m_retries;
        req_reset = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge refclk); vec++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL req_hold cycle %0d: got %b expected %b", j, obs, expv);
            end
            if (pll_rst) pr_cnt++;
            if (lock_lost) lost_cnt++;
            if (j == 10) req_reset = 1'b0;
        end
        vec++;
        if (pr_cnt !== 10 + RC - 1) begin
            errs++; $display("FAIL req_hold_pll_rst: got %0d cycles expected %0d", pr_cnt, 10 + RC - 1);
        end
        vec++;
        if (lost_cnt !== 0 || retries !== 8'(r0) || ready !== 1'b1) begin
            errs++;
            $display("FAIL req_hold_side: lost %0d retries %0d ready %b expected 0 %0d 1", lost_cnt, retries, ready, r0);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 1000; i++) begin
            @(negedge refclk); vec++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL random cycle %0d: got %b expected %b", i, obs, expv);
            end
            if ($urandom_range(0, 99) < ((i < 500) ? 6 : 2)) pll_locked = ~pll_locked;
            req_reset = ($urandom_range(0, 199) == 0);
        end
        req_reset = 1'b0;
    endtask

    task automatic test_timeout;
        int last_rise = -1;
        logic prev;
        pll_locked = 1'b0;
        req_reset  = 1'b1;
        @(negedge refclk); vec++;
        if (obs !== expv) begin
            errs++; $display("FAIL timeout_start: got %b expected %b", obs, expv);
        end
        req_reset = 1'b0;
        prev = pll_rst;
        for (int i = 1; i <= 300 * (RC + LT); i++) begin
            @(negedge refclk); vec++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL timeout cycle %0d: got %b expected %b", i, obs, expv);
            end
            if (pll_rst && !prev) begin
                if (last_rise >= 0) begin
                    vec++;
                    if (i - last_rise !== RC + LT) begin
                        errs++; $display("FAIL timeout_period: got %0d expected %0d", i - last_rise, RC + LT);
                    end
                end
                last_rise = i;
            end
            prev = pll_rst;
        end
        vec++;
        if (retries !== 8'd255) begin
            errs++; $display("FAIL timeout_saturate: retries got %0d expected 255", retries);
        end
    endtask

    task automatic test_async_rst;
        bit found = 0;
        pll_locked = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge refclk); vec++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL async_approach cycle %0d: got %b expected %b", i, obs, expv);
            end
            if (dom_rst === 3'b100) found = 1;
        end
        vec++;
        if (!found) begin
            errs++; $display("FAIL async_reach_release: dom_rst got %b expected 100 within 200 cycles", dom_rst);
        end else begin
            #2 rst = 1'b1;
            #1;
            if (obs !== {1'b1, 3'b111, 1'b0, 8'd0, 1'b0}) begin
                errs++;
                $display("FAIL async_rst: got %b expected %b", obs, {1'b1, 3'b111, 1'b0, 8'd0, 1'b0});
            end
            vec++;
            if (obs !== expv) begin
                errs++; $display("FAIL async_rst_model: got %b expected %b", obs, expv);
            end
        end
        @(negedge refclk);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge refclk); vec++;
            if (obs !== expv) begin
                errs++;
                $display("FAIL async_after cycle %0d: got %b expected %b", i, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_glitch();
        test_lock_loss();
        test_req_hold();
        test_random();
        test_timeout();
        test_async_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Reset and lock sequencer for the core's 3-output fractional PLL (28.75 / 3.59375 / 86.25 MHz from 50 MHz).
- Runs on the free-running 50 MHz reference clock.
- Pulses the PLL reset and waits for a filtered, stable lock, retrying on timeout.
- Releases the per-domain resets in a staggered order.
- Re-runs the whole sequence on lock loss or on request.
- Sits between the board reset and the PLL/core resets.

## Interface
- RST_CYCLES, 16: width of the PLL reset pulse, in refclk cycles (≥1).
- LOCK_FILTER, 1024: consecutive synchronized-locked cycles required before the lock is accepted (≥1).
- LOCK_TIMEOUT, 1000000: cycles allowed in WAIT_LOCK+FILTER before the PLL is reset again (>LOCK_FILTER).
- STAGGER, 64: spacing in cycles between successive domain reset releases (≥1).
- NUM_DOM, 3: number of domain resets.
- refclk  in  1  free-running 50 MHz clock; all logic is on this edge.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock, asynchronous to refclk; passes through a 2-flop synchronizer (locked_s).
- req_reset  in  1  synchronous to refclk; while high, forces a full re-sequence.
- pll_rst  out  1  reset to the PLL.
- dom_rst  out  NUM_DOM  per-domain resets; 1 = held in reset.
- ready  out  1  high only in RUN.
- retries  out  8  saturating count of lock timeouts since rst.
- lock_lost  out  1  one-cycle pulse on lock loss after the lock was accepted.

## Operation
- All outputs are registered. Values while rst is high:
  - pll_rst=1, dom_rst=all 1s, ready=0, retries=0, lock_lost=0.
  - State is PLL_RST with cnt=0; both synchronizer flops are 0.
- FSM states: PLL_RST, WAIT_LOCK, FILTER, RELEASE, RUN. Counters:
  - cnt: phase counter, cleared on every state change.
  - tmo: timeout counter, cleared on entry to WAIT_LOCK from PLL_RST.
- PLL_RST
  - pll_rst=1, dom_rst=all 1s. cnt increments each cycle.
  - At cnt==RST_CYCLES-1 with req_reset=0 → WAIT_LOCK.
  - While req_reset=1, cnt holds at 0.
- WAIT_LOCK
  - pll_rst=0. tmo increments.
  - locked_s=1 → FILTER.
- FILTER
  - tmo keeps incrementing. cnt counts consecutive cycles with locked_s=1.
  - locked_s=0 → WAIT_LOCK. tmo is not cleared; no lock_lost pulse.
  - At cnt==LOCK_FILTER-1 with locked_s=1 → RELEASE.
- Timeout
  - In WAIT_LOCK or FILTER, at tmo==LOCK_TIMEOUT-1 → PLL_RST; retries += 1, saturating at 255.
  - Timeout takes priority over the FILTER→RELEASE transition in the same cycle.
- RELEASE
  - cnt increments.
  - dom_rst[i] clears at cnt==STAGGER*i. Released bits stay cleared until a re-sequence.
  - At the cycle after dom_rst[NUM_DOM-1] clears → RUN.
- RUN
  - ready=1.
- Lock loss in RELEASE or RUN (locked_s=0) takes effect next edge:
  - dom_rst=all 1s, ready=0, lock_lost=1 for exactly one cycle.
  - → PLL_RST. retries is unchanged.
- req_reset=1 in any state other than PLL_RST, next edge:
  - → PLL_RST; dom_rst=all 1s, ready=0.
  - No lock_lost pulse; retries is unchanged.
- Priority when events coincide: rst > req_reset > lock loss > timeout > normal transition.
- rst mid-sequence: all state returns to the reset values immediately and asynchronously, including retries.

## Timing
- pll_locked to locked_s: 2 refclk cycles.
- rst deassert edge (edge 0): pll_rst is high through edge RST_CYCLES-1; cleared by the edge at cnt==RST_CYCLES-1 (edge RST_CYCLES).
- Lock acceptance: from the first cycle locked_s=1 in WAIT_LOCK, RELEASE is entered LOCK_FILTER+1 edges later.
- Release spacing: dom_rst[i] clears exactly STAGGER*i cycles after dom_rst[0].
- ready rises 1 cycle after dom_rst[NUM_DOM-1] clears.
- Lock loss: locked_s falling → dom_rst all 1s, lock_lost=1, ready=0 on the next edge. pll_rst=1 from that same edge.
- Re-sequence: pll_rst stays high for RST_CYCLES cycles from that edge, as after rst.
- Counter widths:
  - cnt wide enough for max(RST_CYCLES, LOCK_FILTER, STAGGER*(NUM_DOM-1)+1).
  - tmo wide enough for LOCK_TIMEOUT.
  - Neither counter wraps.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_FILTER=8, LOCK_TIMEOUT=100, STAGGER=2, NUM_DOM=3.
- Clean bring-up: rst pulse, pll_locked=1 from 10 cycles after rst → pll_rst high 4 cycles; dom_rst goes 111→110→100→000 at 2-cycle spacing; ready=1 one cycle later; retries=0.
- Glitchy lock: pll_locked high 5 cycles, low 1, then steady → no release until 8 consecutive locked_s cycles; lock_lost stays 0.
- Timeout: pll_locked held 0 → pll_rst re-pulses every 104 cycles; retries increments 1,2,3…; force retries to 255 → stays 255.
- Lock loss in RUN: drop pll_locked → 2 cycles later plus 1 edge: lock_lost single pulse, dom_rst=111, ready=0, pll_rst=1; then full re-sequence after lock returns.
- req_reset in RUN held 10 cycles → pll_rst high for 10+3 cycles total after the hold; no lock_lost; retries unchanged.
- Async rst mid-RELEASE with dom_rst=100 → immediately dom_rst=111, pll_rst=1, ready=0, retries=0, without waiting for an edge.
